// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values used by the ALU control decoder and
// the execute-stage FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_MUL  = 4'b0110;
  localparam logic [3:0] ALU_RELU = 4'b0111;
  localparam logic [3:0] ALU_MAXP = 4'b1000;
  localparam logic [3:0] ALU_FC   = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_multi(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_FC);
  endfunction

  function automatic logic signed [15:0] max4(input logic signed [15:0] a,
                                              input logic signed [15:0] b,
                                              input logic signed [15:0] c,
                                              input logic signed [15:0] d);
    logic signed [15:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, one multiplier bit per step; product is the running
// sum including the current step, so it is final while last is high.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic             last
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] sum;
  logic [CW-1:0]    cnt;

  assign product = sum + (mplier[0] ? mcand : '0);
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      sum    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      sum    <= '0;
      cnt    <= '0;
    end else if (step) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      sum    <= product;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops plus multi-cycle
// MUL and FC (multiply-accumulate) with a valid/ready request handshake.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             acc_clr_i,
  input  logic             flush_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o
);

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               start_multi;
  logic [3:0]         op_q;
  logic               clr_q;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   single_res;
  logic [WIDTH-1:0]   mac_res;
  logic [WIDTH-1:0]   mul_product;
  logic               mul_last;
  logic signed [15:0] pool_max;

  assign ready_o     = (state != S_ITER);
  assign busy_o      = (state == S_ITER);
  assign accept      = in_valid_i && ready_o && !flush_i;
  assign start_multi = accept && is_multi(ALUCtrl_i);

  seq_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .start   (start_multi),
    .step    (busy_o),
    .a       (src1_i),
    .b       (src2_i),
    .product (mul_product),
    .last    (mul_last)
  );

  // Single-cycle results are computed straight from the inputs at acceptance.
  always_comb begin
    pool_max   = max4(src1_i[31:16], src1_i[15:0], src2_i[31:16], src2_i[15:0]);
    single_res = '0;
    case (ALUCtrl_i)
      ALU_SUB:  single_res = src1_i - src2_i;
      ALU_AND:  single_res = src1_i & src2_i;
      ALU_OR:   single_res = src1_i | src2_i;
      ALU_RELU: single_res = src1_i[WIDTH-1] ? '0 : src1_i;
      ALU_MAXP: single_res = {{(WIDTH-16){pool_max[15]}}, pool_max};
      default:  single_res = src1_i + src2_i;
    endcase
  end

  assign mac_res = (op_q == ALU_FC) ? ((clr_q ? '0 : acc) + mul_product) : mul_product;

  always_comb begin
    state_next = state;
    case (state)
      S_ITER: begin
        if (flush_i)       state_next = S_IDLE;
        else if (mul_last) state_next = S_DONE;
      end
      default: begin
        if (accept) state_next = is_multi(ALUCtrl_i) ? S_ITER : S_DONE;
        else        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_IDLE;
      done_o   <= 1'b0;
      result_o <= '0;
      zero_o   <= 1'b1;
      acc      <= '0;
      op_q     <= '0;
      clr_q    <= 1'b0;
    end else begin
      state  <= state_next;
      done_o <= (state_next == S_DONE);
      if (accept) begin
        op_q  <= ALUCtrl_i;
        clr_q <= acc_clr_i;
      end
      if (accept && !is_multi(ALUCtrl_i)) begin
        result_o <= single_res;
        zero_o   <= (single_res == '0);
      end else if (busy_o && mul_last && !flush_i) begin
        result_o <= mac_res;
        zero_o   <= (mac_res == '0);
        if (op_q == ALU_FC) acc <= mac_res;
      end
    end
  end

endmodule
